// File: rtl/mux4_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux4_arb_pkg
//   Shared definitions for the 4-requester round-robin mux arbiter:
//   arbiter state encoding, requester count, select width and the default
//   forced-release hold limit.
// -----------------------------------------------------------------------------
package mux4_arb_pkg;

  localparam int NREQ         = 4;
  localparam int SELW         = 2;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
//   Combinational rotating-priority pick over four requests. The candidate at
//   ptr has highest priority, then ptr+1, ptr+2, ptr+3 (mod 4).
//
//   Ports
//     req    [3:0] : request vector
//     ptr    [1:0] : index holding highest priority
//     hit          : at least one request is present
//     idx    [1:0] : index of the winning requester (ptr when no hit)
//     onehot [3:0] : one-hot form of idx, all zero when no hit
// -----------------------------------------------------------------------------
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            hit,
  output logic [SELW-1:0] idx,
  output logic [NREQ-1:0] onehot
);

  logic [SELW-1:0] cand;

  // Walk from the farthest offset down to offset 0 so the last match written
  // is the one closest to ptr, i.e. the highest-priority requester.
  always_comb begin
    hit  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + SELW'(k);
      if (req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
    onehot = hit ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter owning the select of a shared 4:1 one-bit mux. One
//   requester is granted at a time and keeps the grant until it drops its
//   request; a one-cycle GAP follows every release, during which the next
//   owner is chosen starting after the previous owner. The selected data bit
//   is registered onto y one cycle behind the grant.
//
//   Optional feature macro: MUX4_ARB_TIMEOUT_EN
//     When defined, an owner that has held the grant for MAX_HOLD cycles is
//     forced off if any other requester is waiting.
//
//   Parameters
//     MAX_HOLD : forced-release limit in GRANT cycles (2..255), timeout only
//
//   Ports
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset
//     req  [3:0] : per-requester request, held high while the mux is needed
//     d    [3:0] : per-requester data bit, d[i] is mux input i
//     gnt  [3:0] : one-hot grant or zero
//     sel  [1:0] : index of the granted requester; the external mux has s0
//                  wired to sel[1] and s1 to sel[0]
//     y          : registered d[sel]
//     y_vld      : y was captured while a grant was active
//     busy       : a grant is active
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] d,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel,
  output logic            y,
  output logic            y_vld,
  output logic            busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  arb_state_e      state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            y_p1, y_vld_p1;

  logic            pick_hit;
  logic [SELW-1:0] pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic            owner_req;
  logic            force_rel;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .hit    (pick_hit),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign owner_req = req[sel_q];

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       hold_last;
  logic       others_req;

  // hold_cnt_q counts GRANT cycles already completed; the current cycle is
  // number hold_cnt_q+1, so the limit is reached when that equals MAX_HOLD.
  assign hold_last  = (9'(hold_cnt_q) + 9'd1) >= 9'(MAX_HOLD);
  assign others_req = |(req & ~gnt_q);
  assign force_rel  = hold_last & others_req;

  // Held at zero outside GRANT so every new grant starts from a cleared
  // count; saturates once the limit is reached with nobody waiting.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q != GRANT) begin
      hold_cnt_d = '0;
    end else if (!hold_last) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  // Arbitration happens only in IDLE and GAP, so a release and a competing
  // request on the same edge always pass through one dead GAP cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE, GAP: begin
        if (pick_hit) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = pick_onehot;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (!owner_req || force_rel) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = sel_q + SELW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // ---- stage p0: arbitration state, pointer, select and grant ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  // ---- stage p1: registered mux output, one cycle behind the grant ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1     <= 1'b0;
      y_vld_p1 <= 1'b0;
    end else if (state_q == GRANT) begin
      y_p1     <= d[sel_q];
      y_vld_p1 <= 1'b1;
    end else begin
      y_p1     <= 1'b0;
      y_vld_p1 <= 1'b0;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign y     = y_p1;
  assign y_vld = y_vld_p1;
  assign busy  = |gnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 16;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       y_vld;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int step_n = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       vld;
    int         step;
  } exp_t;

  exp_t exp_q[$];

  mux4_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .gnt   (gnt),
    .sel   (sel),
    .y     (y),
    .y_vld (y_vld),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int stp, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%b want=%b", nm, stp, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next
  // rising edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] dd, input logic [3:0] eg,
                     input logic [1:0] es, input logic ey, input logic ev);
    exp_t e;
    @(negedge clk);
    req = r;
    d   = dd;
    e.gnt  = eg;
    e.sel  = es;
    e.y    = ey;
    e.vld  = ev;
    e.step = step_n;
    exp_q.push_back(e);
    step_n++;
  endtask

  // Reset pulsed between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    req = 4'b0000;
    d   = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt",   step_n, gnt, 4'b0000);
    chk("rst_sel",   step_n, {2'b00, sel}, 4'b0000);
    chk("rst_y",     step_n, {3'b000, y}, 4'b0000);
    chk("rst_y_vld", step_n, {3'b000, y_vld}, 4'b0000);
    chk("rst_busy",  step_n, {3'b000, busy}, 4'b0000);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compares every queued expectation just after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",   e.step, gnt, e.gnt);
        chk("sel",   e.step, {2'b00, sel}, {2'b00, e.sel});
        chk("y",     e.step, {3'b000, y}, {3'b000, e.y});
        chk("y_vld", e.step, {3'b000, y_vld}, {3'b000, e.vld});
        chk("busy",  e.step, {3'b000, busy}, {3'b000, |e.gnt});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] dv;
    logic [3:0] oh;
    logic [1:0] k;
    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'b0000;
    do_reset();

    // Single requester 0: grant latency 1, y one cycle later.
    cyc(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
    cyc(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    cyc(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // All four requesting, each owner holds 3 cycles: order 0,1,2,3,0.
    do_reset();
    dv = 4'b1010;
    for (int r = 0; r < 5; r++) begin
      k  = 2'(r % 4);
      oh = 4'b0001 << k;
      cyc(4'b1111, dv, oh, k, 1'b0, 1'b0);
      cyc(4'b1111, dv, oh, k, dv[k], 1'b1);
      cyc(4'b1111, dv, oh, k, dv[k], 1'b1);
      cyc(4'b1111 & ~oh, dv, 4'b0000, k, dv[k], 1'b1);
    end
    cyc(4'b0000, dv, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner 3 releases; pointer wraps to 0 so 0 beats 1 and 3 in GAP.
    cyc(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0);
    cyc(4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
    cyc(4'b0001, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b1);
    cyc(4'b1011, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner 1 holds while 2 waits; 2 granted only after the GAP.
    cyc(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0);
    cyc(4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
    cyc(4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1);
    cyc(4'b0100, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1);
    cyc(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0);
    cyc(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);

    // Reset mid-grant, then pointer back at 0 gives 0110 to requester 1.
    @(posedge clk);
    #2;
    do_reset();
    cyc(4'b0110, 4'b0110, 4'b0010, 2'd1, 1'b0, 1'b0);
    cyc(4'b0110, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

    do_reset();
`ifdef MUX4_ARB_TIMEOUT_EN
    // Owner 0 forced off after 4 GRANT cycles because 1 is waiting.
    cyc(4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    cyc(4'b0011, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);
    cyc(4'b0011, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    // Alone, owner 0 keeps the grant well past the limit.
    cyc(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    cyc(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    // Without the timeout, owner 0 is never preempted even with 1 waiting.
    cyc(4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    cyc(4'b0010, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);
    cyc(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0);
    cyc(4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b1);
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 one-bit mux datapath between four requesters. It owns the mux select, grants one requester at a time, and holds the grant until the requester releases it. It also registers the selected data bit as the shared output. It sits between four client blocks and the downstream consumer of the muxed bit.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before forced release; used only with the timeout feature; legal range 2..255.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 4: request per requester; a requester holds its bit high for as long as it needs the mux.
- `d` input 4: data bit per requester; `d[i]` corresponds to mux input `i`.
- `gnt` output 4: one-hot grant, or all zero.
- `sel` output 2: mux select, equal to the index of the granted requester. `sel[1]` drives s0 and `sel[0]` drives s1.
- `y` output 1: registered `d[sel]`.
- `y_vld` output 1: `y` is valid for the current owner.
- `busy` output 1: a grant is active.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one owner.
  - GAP: one-cycle dead time after a release.
- Arbitration:
  - Performed in IDLE and GAP.
  - Candidates are scanned from `ptr`, `ptr+1`, … mod 4; the first requester with `req` high wins.
  - `ptr` is a 2-bit pointer, reset to 0.
  - No requests: stay in or enter IDLE.
- GRANT:
  - The owner is held while `req[owner]` is high.
  - On the edge where `req[owner]` is sampled low: `gnt` goes to 0, the state goes to GAP, and `ptr` becomes owner+1 mod 4 (wrap 3→0).
  - Requests from other requesters are ignored while a grant is active. No preemption unless the timeout feature is compiled in.
- `sel`:
  - Updates only when a new grant is issued.
  - Holds its last value in IDLE and GAP.
- `y`/`y_vld`:
  - In GRANT, each edge loads `y <= d[sel]` and sets `y_vld` to 1.
  - Otherwise `y_vld` goes to 0 and `y` goes to 0.
- `busy` equals `|gnt`.
- Simultaneous events:
  - Owner release and other requests on the same edge: the release wins, and the others are arbitrated only in GAP.
  - A requester that drops `req` before being granted is simply not granted.
- Invariant: `gnt` is never multi-hot.

## Timing
- Reset values: `gnt`=0, `sel`=0, `y`=0, `y_vld`=0, `busy`=0, `ptr`=0, state IDLE, hold counter 0.
- Asserting `rst_n` mid-grant clears all outputs immediately, without waiting for a clock edge.
- Grant latency: `req` sampled high at edge N in IDLE gives `gnt` high after edge N, i.e. 1 cycle.
- Release latency: `req[owner]` sampled low at edge N gives `gnt` low after edge N.
- Back-to-back handover: the next grant comes after edge N+1, so there are 2 edges between one release and the next grant, with exactly one dead cycle.
- `y` lags `gnt`/`sel` by one cycle. The first valid `y` appears after the edge following grant assertion.

## Configuration
- `MUX4_ARB_TIMEOUT_EN`
  - Defined:
    - A hold counter counts GRANT cycles.
    - When the count reaches `MAX_HOLD` and any other `req` is high, the grant is force-released: GAP, `ptr` = owner+1.
    - If the old owner still requests, it competes normally, at lowest priority.
    - If no other requester is waiting, the counter saturates and the grant continues.
    - The counter clears on entry to GRANT.
  - Undefined: no counter; the grant is held indefinitely. `MAX_HOLD` is unused.

## Structure
- Package `mux4_arb_pkg`:
  - state enum (IDLE, GRANT, GAP);
  - `NREQ`=4 and `SELW`=2 constants;
  - default `MAX_HOLD`.
- Sub-module `rr_pick4`: combinational rotating priority pick. It takes `req[3:0]` and `ptr[1:0]` and produces `hit`, `idx[1:0]`, and `onehot[3:0]`.
- Top level: FSM, `ptr`, `sel`/`gnt` registers, output register, optional hold counter.

## Test plan
- Reset, then `req`=0001 → `gnt`=0001 and `sel`=00 after 1 edge. With `d`=0001, `y`=1 and `y_vld`=1 one edge later.
- All `req`=1111 held, each owner releasing after 3 cycles → grant order 0,1,2,3,0, with a one-cycle GAP (`gnt`=0000) between each grant.
- Owner 3 releases while `req`=1001 → `ptr` wraps to 0, and the next grant is 0001.
- Owner 1 is granted, then `req[2]` rises while owner 1 holds → `gnt` stays 0010 until `req[1]` drops, then goes to 0100 after GAP.
- `rst_n` pulsed low mid-GRANT between edges → `gnt`, `y`, `y_vld`, `busy` are 0 immediately. After release, `req`=0110 is granted to 1, because `ptr` was reset to 0.
- With `MUX4_ARB_TIMEOUT_EN` and `MAX_HOLD`=4, `req`=0011 held → owner 0 is forced off after 4 GRANT cycles, GAP follows, then 0010 is granted. With only `req`=0001 held, the grant persists beyond 4 cycles.
